// File: rtl/s_stream_rx.sv
// s_stream_rx: receive side of the S-sequence stream. Requests packed S words
// from the host, holds them in a two-slot ping-pong store and serialises one
// base per cycle (MSB-first) toward the PE-array input stage.
module s_stream_rx #(
  parameter int PE_SIZE_LOG = 6,
  parameter int BASE_W      = 2,
  parameter int DATA_W      = 128,
  parameter int CNT_W       = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_start,
  input  logic                   i_clear,
  output logic                   o_request_s,
  input  logic [DATA_W-1:0]      i_s,
  input  logic [PE_SIZE_LOG:0]   i_s_valid,
  output logic [BASE_W-1:0]      o_base,
  output logic                   o_base_valid,
  input  logic                   i_base_ready,
  output logic                   o_last,
  output logic                   o_done,
  output logic                   o_busy,
  output logic [CNT_W-1:0]       o_count
);

  localparam int TAG_W = PE_SIZE_LOG + 1;
  localparam int SH_W  = $clog2(DATA_W) + 1;
  localparam logic [TAG_W-1:0] WORD_BASES = TAG_W'(2 ** PE_SIZE_LOG);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DRAIN,
    ST_DONE
  } state_t;

  state_t r_state, w_state_nxt;

  logic [DATA_W-1:0]      r_slot_data [2];
  logic [TAG_W-1:0]       r_slot_cnt  [2];   // bases held in slot, 0 = empty
  logic                   r_wr_ptr;
  logic                   r_rd_ptr;
  logic                   r_last_slot;       // slot holding the final word
  logic [PE_SIZE_LOG-1:0] r_rd_idx;
  logic                   r_outstanding;
  logic                   r_last_rcvd;
  logic                   r_req;
  logic [CNT_W-1:0]       r_count;

  logic [TAG_W-1:0]  w_rd_cnt;
  logic              w_active;
  logic              w_base_valid;
  logic              w_xfer;
  logic              w_idx_end;
  logic              w_last;
  logic              w_wr_free;
  logic              w_tag_final;
  logic [TAG_W-1:0]  w_wr_cnt;
  logic              w_accept;
  logic              w_req_set;
  logic [SH_W-1:0]   w_shamt;
  logic [DATA_W-1:0] w_rd_word;

  // Read-side view, handshake, word decode and request qualification
  always_comb begin
    w_rd_cnt     = r_slot_cnt[r_rd_ptr];
    w_active     = (r_state == ST_FETCH) || (r_state == ST_DRAIN);
    w_base_valid = w_active && (w_rd_cnt != '0);
    w_xfer       = w_base_valid && i_base_ready;
    w_idx_end    = ({1'b0, r_rd_idx} == (w_rd_cnt - TAG_W'(1)));
    w_last       = w_base_valid && r_last_rcvd && (r_rd_ptr == r_last_slot) && w_idx_end;
    w_wr_free    = (r_slot_cnt[r_wr_ptr] == '0);
    // Tags above one full word (including all-ones) mean "full word, more follow"
    w_tag_final  = (i_s_valid != '0) && (i_s_valid <= WORD_BASES);
    w_wr_cnt     = w_tag_final ? i_s_valid : WORD_BASES;
    // Words arriving with no free slot are silently dropped
    w_accept     = (r_state == ST_FETCH) && (i_s_valid != '0) && w_wr_free;
    // The write slot is only occupied when both slots are, so it alone gates requests
    w_req_set    = (r_state == ST_FETCH) && w_wr_free && !r_outstanding &&
                   !r_last_rcvd && !w_accept;
    w_shamt      = SH_W'(r_rd_idx) * SH_W'(BASE_W);
    w_rd_word    = r_slot_data[r_rd_ptr] << w_shamt;
  end

  assign o_base_valid = w_base_valid;
  assign o_base       = w_base_valid ? w_rd_word[DATA_W-1 -: BASE_W] : '0;
  assign o_last       = w_last;
  assign o_request_s  = r_req;
  assign o_done       = (r_state == ST_DONE);
  assign o_busy       = (r_state != ST_IDLE);
  assign o_count      = r_count;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic; clear overrides every transition
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE:  if (i_start) w_state_nxt = ST_FETCH;
      ST_FETCH: if (w_accept && w_tag_final) w_state_nxt = ST_DRAIN;
      ST_DRAIN: if (w_xfer && w_last) w_state_nxt = ST_DONE;
      ST_DONE:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
    if (i_clear) w_state_nxt = ST_IDLE;
  end

  // Slot store, pointers, request/outstanding tracking and base counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_slot_data[0] <= '0;
      r_slot_data[1] <= '0;
      r_slot_cnt[0]  <= '0;
      r_slot_cnt[1]  <= '0;
      r_wr_ptr       <= 1'b0;
      r_rd_ptr       <= 1'b0;
      r_last_slot    <= 1'b0;
      r_rd_idx       <= '0;
      r_outstanding  <= 1'b0;
      r_last_rcvd    <= 1'b0;
      r_req          <= 1'b0;
      r_count        <= '0;
    end else if (i_clear) begin
      r_slot_cnt[0]  <= '0;
      r_slot_cnt[1]  <= '0;
      r_wr_ptr       <= 1'b0;
      r_rd_ptr       <= 1'b0;
      r_last_slot    <= 1'b0;
      r_rd_idx       <= '0;
      r_outstanding  <= 1'b0;
      r_last_rcvd    <= 1'b0;
      r_req          <= 1'b0;
      r_count        <= '0;
    end else begin
      r_req <= w_req_set;
      if (w_req_set) r_outstanding <= 1'b1;

      if ((r_state == ST_IDLE) && i_start) begin
        r_wr_ptr      <= 1'b0;
        r_rd_ptr      <= 1'b0;
        r_rd_idx      <= '0;
        r_outstanding <= 1'b0;
        r_last_rcvd   <= 1'b0;
        r_count       <= '0;
      end

      // A write and a free in the same cycle always target different slots
      if (w_accept) begin
        r_slot_data[r_wr_ptr] <= i_s;
        r_slot_cnt[r_wr_ptr]  <= w_wr_cnt;
        r_wr_ptr              <= ~r_wr_ptr;
        r_outstanding         <= 1'b0;
        if (w_tag_final) begin
          r_last_rcvd <= 1'b1;
          r_last_slot <= r_wr_ptr;
        end
      end

      if (w_xfer) begin
        if (r_count != '1) r_count <= r_count + CNT_W'(1);
        if (w_idx_end) begin
          r_slot_cnt[r_rd_ptr] <= '0;
          r_rd_ptr             <= ~r_rd_ptr;
          r_rd_idx             <= '0;
        end else begin
          r_rd_idx <= r_rd_idx + PE_SIZE_LOG'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_s_stream_rx.sv
// tb_s_stream_rx: directed bench for s_stream_rx. A host model answers each
// request with the next tagged word; the sink checks every base in order.
module tb_s_stream_rx;

  localparam int DW = 128;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          i_start = 1'b0;
  logic          i_clear = 1'b0;
  logic          i_base_ready = 1'b0;
  logic [DW-1:0] i_s = '0;
  logic [6:0]    i_s_valid = '0;
  logic          o_request_s;
  logic [1:0]    o_base;
  logic          o_base_valid;
  logic          o_last;
  logic          o_done;
  logic          o_busy;
  logic [15:0]   o_count;

  s_stream_rx #(
    .PE_SIZE_LOG(6),
    .BASE_W(2),
    .DATA_W(DW),
    .CNT_W(16)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .i_start(i_start),
    .i_clear(i_clear),
    .o_request_s(o_request_s),
    .i_s(i_s),
    .i_s_valid(i_s_valid),
    .o_base(o_base),
    .o_base_valid(o_base_valid),
    .i_base_ready(i_base_ready),
    .o_last(o_last),
    .o_done(o_done),
    .o_busy(o_busy),
    .o_count(o_count)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  int   tags[$];
  int   host_widx, got, exp_len, seed, n_req_rise, done_seen;
  int   stall_at, stall_n, stall_left, start_at;
  logic prev_req;
  logic [1:0] held;

  function automatic logic [1:0] exp_base(int k);
    return 2'((k * 5 + (k >> 2) + seed) & 3);
  endfunction

  function automatic logic [DW-1:0] mk_word(int widx);
    logic [DW-1:0] w;
    w = '0;
    for (int j = 0; j < 64; j++) w[DW-1-2*j -: 2] = exp_base(64 * widx + j);
    return w;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic new_seq(input int len, input int sd);
    got = 0; host_widx = 0; exp_len = len; seed = sd;
    n_req_rise = 0; done_seen = 0; prev_req = 1'b0;
    stall_at = -1; stall_n = 0; stall_left = 0; start_at = -1;
  endtask

  // One clock: host response, sink handshake and per-base checks at negedge
  task automatic cycle();
    @(negedge clk);
    i_start = 1'b0;
    if (o_request_s && !prev_req) n_req_rise++;
    prev_req  = o_request_s;
    i_s_valid = '0;
    if (o_request_s && host_widx < tags.size()) begin
      i_s       = mk_word(host_widx);
      i_s_valid = 7'(tags[host_widx]);
      host_widx++;
    end
    if (got == start_at) begin
      i_start  = 1'b1;
      start_at = -1;
    end
    if (stall_left > 0 && got >= stall_at) begin
      i_base_ready = 1'b0;
      if (stall_left == stall_n) held = o_base;
      else chk("stall_hold", {29'd0, o_base_valid, o_base}, {29'd0, 1'b1, held});
      if (stall_left == 1) begin
        chk("stall_req", 32'(o_request_s), 0);
        chk("stall_words", host_widx, 2);
      end
      stall_left--;
    end else begin
      i_base_ready = 1'b1;
    end
    if (o_base_valid && i_base_ready) begin
      chk("base", 32'(o_base), 32'(exp_base(got)));
      chk("last", 32'(o_last), 32'(got == exp_len - 1));
      chk("count", 32'(o_count), got);
      got++;
    end
    if (o_done) done_seen++;
  endtask

  task automatic start_seq();
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    chk("start_busy", 32'(o_busy), 1);
    chk("start_count", 32'(o_count), 0);
  endtask

  task automatic run_xfer(input int target, input int budget);
    int n;
    n = 0;
    while (got < target && n < budget) begin
      cycle();
      n++;
    end
    chk("reach_target", got, target);
  endtask

  task automatic check_done();
    cycle();
    chk("done_pulse", 32'(o_done), 1);
    chk("final_count", 32'(o_count), exp_len);
    cycle();
    chk("done_idle", {30'd0, o_done, o_busy}, 0);
    chk("count_hold", 32'(o_count), exp_len);
    chk("done_once", done_seen, 1);
  endtask

  function automatic logic [31:0] all_outs();
    return 32'({o_request_s, o_base, o_base_valid, o_last, o_done, o_busy, o_count});
  endfunction

  initial begin
    #1 rst_n = 1'b0;
    #1 chk("reset_outs", all_outs(), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // 150 bases over three words
    tags = '{127, 127, 22};
    new_seq(150, 1);
    start_seq();
    run_xfer(150, 400);
    check_done();
    chk("t1_req_edges", n_req_rise, 3);
    chk("t1_words", host_widx, 3);

    // Exactly one full final word
    tags = '{64};
    new_seq(64, 2);
    start_seq();
    run_xfer(64, 200);
    check_done();
    chk("t2_req_edges", n_req_rise, 1);

    // 200 bases with a 100-cycle stall after base 30
    tags = '{127, 127, 127, 8};
    new_seq(200, 3);
    stall_at = 30; stall_n = 100; stall_left = 100;
    start_seq();
    run_xfer(200, 600);
    check_done();
    chk("t3_req_edges", n_req_rise, 4);

    // Single base, then an immediate restart
    tags = '{1};
    new_seq(1, 4);
    start_seq();
    run_xfer(1, 50);
    check_done();
    tags = '{127, 5};
    new_seq(69, 5);
    start_seq();
    run_xfer(69, 300);
    check_done();

    // Start while busy is ignored; clear after base 70
    tags = '{127, 127, 22};
    new_seq(150, 6);
    start_at = 40;
    start_seq();
    run_xfer(70, 300);
    @(negedge clk);
    i_clear = 1'b1; i_base_ready = 1'b0; i_s_valid = '0;
    @(negedge clk);
    i_clear = 1'b0;
    chk("clear_state", {28'd0, o_busy, o_base_valid, o_request_s, o_last}, 0);
    chk("clear_count", 32'(o_count), 0);
    tags = {};
    done_seen = 0;
    repeat (5) cycle();
    chk("clear_no_done", done_seen, 0);
    chk("clear_idle", 32'(o_busy), 0);
    tags = '{64};
    new_seq(64, 7);
    start_seq();
    run_xfer(64, 200);
    check_done();

    // Asynchronous reset mid-drain, then a 65-base sequence
    tags = '{127, 127, 22};
    new_seq(150, 8);
    start_seq();
    run_xfer(140, 400);
    chk("pre_reset_busy", 32'(o_busy), 1);
    #2 rst_n = 1'b0;
    #1 chk("async_reset", all_outs(), 0);
    i_s_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;
    tags = '{127, 1};
    new_seq(65, 9);
    start_seq();
    run_xfer(65, 300);
    check_done();
    chk("t6_req_edges", n_req_rise, 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/s_stream_rx.md
Name: s_stream_rx

Overview:
- Receive side of the S-sequence streaming interface inside SmithWaterman.
- Issues o_request_s to the host-side feeder and accepts 128-bit packed S words (64 bases × 2 bits) tagged with an i_s_valid count.
- Buffers incoming words in a two-slot ping-pong store.
- Serialises one base per cycle, with a ready/valid handshake, toward the PE-array input stage.

Parameters:
- PE_SIZE_LOG, 6, log2 of bases per word (64).
- BASE_W, 2, bits per base.
- DATA_W, 128, word width; must equal BASE_W << PE_SIZE_LOG.
- CNT_W, 16, width of delivered-base counter.

Ports:
- clk, input, 1, system clock; all state updates on posedge.
- rst_n, input, 1, asynchronous active-low reset.
- i_start, input, 1, one-cycle pulse that begins a new S sequence; ignored unless IDLE.
- i_clear, input, 1, synchronous flush; returns block to IDLE.
- o_request_s, output, 1, request for one S word from host.
- i_s, input, DATA_W, packed S word; base 0 in [DATA_W-1:DATA_W-BASE_W], MSB-first.
- i_s_valid, input, PE_SIZE_LOG+1, word tag:
  - 0 = no word.
  - 1..64 = final word, N valid bases.
  - all-ones = full 64-base word, more follow.
  - 65..126 = illegal; treated as all-ones.
- o_base, output, BASE_W, current base.
- o_base_valid, output, 1, o_base valid.
- i_base_ready, input, 1, downstream accepts base; transfer when valid&ready.
- o_last, output, 1, qualifies o_base as final base of sequence.
- o_done, output, 1, one-cycle pulse after final base transfer.
- o_busy, output, 1, high in any state except IDLE.
- o_count, output, CNT_W, bases transferred in current sequence.

Behaviour:
- Reset (async): all outputs 0, state IDLE, both slots empty, outstanding=0, last_rcvd=0, o_count=0.
- States: IDLE, FETCH, DRAIN, DONE.
- IDLE:
  - i_start → FETCH next cycle; o_count cleared; slot pointers reset to slot 0.
- FETCH:
  - o_request_s is a register: set when at least one slot is free, outstanding=0 and last_rcvd=0.
  - outstanding is set with the request; the request drops the cycle after it is raised if no word has arrived.
  - outstanding holds until a nonzero i_s_valid is sampled.
  - Word acceptance: on posedge with i_s_valid≠0, store i_s and count into the write slot, toggle the write pointer and clear outstanding.
  - If the tag was 1..64, set last_rcvd and go to DRAIN.
  - i_s_valid≠0 while no slot is free is a host protocol error: the word is dropped, state is unchanged, and there is no assertion output.
- Drain path (FETCH and DRAIN):
  - o_base_valid = read slot non-empty.
  - o_base = read slot bits at read index.
  - On each transfer, the read index increments.
  - When the index reaches the slot count−1 on a transfer, the slot is freed, the read pointer toggles and the index resets to 0.
  - o_count increments per transfer, saturating at all-ones.
  - o_last = o_base_valid & last_rcvd & (read slot is the final slot) & (index == count−1).
- DRAIN:
  - No requests issued.
  - After the transfer with o_last high → DONE.
- DONE:
  - o_done=1 for exactly one cycle, then IDLE.
  - o_count holds its value until the next i_start.
- Latency:
  - Word sampled at posedge k gives o_base_valid at posedge k+1 when the read slot was empty.
  - Steady-state throughput is 1 base/cycle with ready held high; the refill round trip is ≤3 cycles, hidden by the second slot.
- Simultaneous events:
  - Write and free of different slots in the same cycle are both honoured.
  - i_clear has priority over everything except reset: state IDLE next cycle, slots emptied, o_request_s/o_base_valid/o_last low, o_count cleared.
  - i_start together with i_clear: clear wins.
- Backpressure: o_base/o_last stay stable while valid & !ready; no base is skipped or repeated.
- Reset mid-operation: immediate return to reset values; no o_done pulse.

Test Plan:
- Sequence of 150 bases, host answers each request with tags 127,127,22 → exactly 3 request rising edges; 150 bases appear in MSB-first order with o_last only on the 150th; o_done 1 cycle later; o_count=150.
- Sequence of exactly 64 bases, tag 64 on first word → 64 bases, o_last on the 64th; no second request; o_count=64.
- 200-base stream, i_base_ready low for 100 cycles after base 30 → o_base constant during the stall; request stops once both slots are full; all 200 bases delivered intact.
- Tag 1 (single base) → one transfer, o_last and o_valid together; o_done next cycle; back-to-back i_start immediately after IDLE restarts cleanly with o_count=0.
- i_start pulsed while busy is ignored; i_clear after base 70 of 150 → IDLE next cycle, o_busy=0, no o_done; a subsequent sequence delivers correctly from base 0.
- rst_n asserted asynchronously mid-DRAIN (between clock edges) → all outputs 0 immediately; post-reset sequence of 65 bases (tags 127,1) delivers correctly.
